player_ctrl: RTL and testbench

Parametrised player controller for the TinyTapeStation game tile grid. It replaces the fixed 16x12 player block. It turns controller buttons into player movement, orientation and timed sword attacks, and it tracks health with invulnerability frames and game-over/restart. All game-logic updates are gated by a per-frame tick. The packed entity words feed the collision and sprite-render stages.

---
 rtl/player_pkg.sv | 27 ++
 rtl/player_timer.sv | 27 ++
 rtl/player_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_player_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared constants, state encoding and entity-word helpers for the player controller.
// The hidden sword word depends on the coordinate width, so a helper builds it.
package player_pkg;

    localparam logic [3:0] PLAYER_ID = 4'h2;
    localparam logic [3:0] SWORD_ID  = 4'h1;
    localparam logic [3:0] HIDDEN_ID = 4'hF;

    localparam logic [1:0] ORIENT_UP    = 2'b00;
    localparam logic [1:0] ORIENT_RIGHT = 2'b01;
    localparam logic [1:0] ORIENT_DOWN  = 2'b10;
    localparam logic [1:0] ORIENT_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ATTACK = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    // Returns {HIDDEN_ID, ORIENT_RIGHT, X=0, Y=0}; callers truncate to 6+2*coord_w bits.
    function automatic logic [63:0] hidden_word(input int coord_w);
        logic [63:0] w;
        w = 64'({HIDDEN_ID, ORIENT_RIGHT});
        return w << (2 * coord_w);
    endfunction

endpackage

// File: rtl/player_timer.sv
// Loadable down-counter that decrements on tick enables and stops at zero.
// A load takes priority over a decrement issued in the same cycle.
module player_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player controller: frame-gated movement, sword attacks, health with i-frames and
// game-over/restart. All outputs come straight from registers.
module player_ctrl
    import player_pkg::*;
#(
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 12,
    parameter int COORD_W       = 4,
    parameter int MAX_HEALTH    = 3,
    parameter int HEALTH_W      = 2,
    parameter int START_X       = 7,
    parameter int START_Y       = 5,
    parameter int MOVE_PERIOD   = 4,
    parameter int ATTACK_FRAMES = 3,
    parameter int IFRAMES       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic                   A,
    input  logic                   B,
    input  logic                   select,
    input  logic                   start,
    input  logic                   up,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   hit,
    output logic [6+2*COORD_W-1:0] player,
    output logic [6+2*COORD_W-1:0] sword,
    output logic [HEALTH_W-1:0]    player_health,
    output logic                   invuln,
    output logic                   game_over,
    output state_t                 dbg_state
);

    localparam int EW = 6 + 2 * COORD_W;
    localparam int MW = $clog2(MOVE_PERIOD + 1);
    localparam int AW = $clog2(ATTACK_FRAMES + 1);
    localparam int IW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;
    localparam logic [EW-1:0] HIDDEN_WORD = EW'(hidden_word(COORD_W));

    state_t                state_q, state_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic [1:0]            orient_q, orient_d;
    logic [EW-1:0]         sword_q, sword_d;
    logic [HEALTH_W-1:0]   health_q, health_d;

    logic                  mv_load, mv_zero;
    logic [MW-1:0]         mv_val, mv_cnt;
    logic                  atk_load, atk_zero;
    logic [AW-1:0]         atk_val, atk_cnt;
    logic                  ifr_load, ifr_zero;
    logic [IW-1:0]         ifr_val, ifr_cnt;

    logic                  dir_pressed, hit_ok, restart, tgt_ok;
    logic [1:0]            dir_orient, o_eff;
    logic [COORD_W-1:0]    tgt_x, tgt_y;

    player_timer #(.WIDTH(MW)) u_move_cd (
        .clk(clk), .reset(reset), .tick(frame_tick), .load(mv_load),
        .load_val(mv_val), .count(mv_cnt), .zero(mv_zero)
    );

    player_timer #(.WIDTH(AW)) u_attack (
        .clk(clk), .reset(reset), .tick(frame_tick), .load(atk_load),
        .load_val(atk_val), .count(atk_cnt), .zero(atk_zero)
    );

    player_timer #(.WIDTH(IW)) u_iframes (
        .clk(clk), .reset(reset), .tick(frame_tick), .load(ifr_load),
        .load_val(ifr_val), .count(ifr_cnt), .zero(ifr_zero)
    );

    // Direction priority and the tile the (possibly new) orientation points at.
    always_comb begin
        dir_pressed = up | down | left | right;
        dir_orient  = ORIENT_RIGHT;
        if (up)         dir_orient = ORIENT_UP;
        else if (down)  dir_orient = ORIENT_DOWN;
        else if (left)  dir_orient = ORIENT_LEFT;
        o_eff = dir_pressed ? dir_orient : orient_q;

        tgt_x  = x_q;
        tgt_y  = y_q;
        tgt_ok = 1'b0;
        case (o_eff)
            ORIENT_UP: begin
                tgt_ok = (y_q != '0);
                tgt_y  = y_q - 1'b1;
            end
            ORIENT_RIGHT: begin
                tgt_ok = (int'(x_q) + 1 < GRID_W);
                tgt_x  = x_q + 1'b1;
            end
            ORIENT_DOWN: begin
                tgt_ok = (int'(y_q) + 1 < GRID_H);
                tgt_y  = y_q + 1'b1;
            end
            default: begin
                tgt_ok = (x_q != '0);
                tgt_x  = x_q - 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        orient_d = orient_q;
        sword_d  = sword_q;
        health_d = health_q;
        mv_load  = 1'b0;
        mv_val   = MW'(MOVE_PERIOD - 1);
        atk_load = 1'b0;
        atk_val  = AW'(ATTACK_FRAMES);

        // Hits are sampled every cycle; guarding on health keeps a zero-length i-frame window from wrapping.
        hit_ok  = hit && ifr_zero && (state_q != ST_DEAD) && (health_q != '0);
        restart = frame_tick && (state_q == ST_DEAD) && start;
        if (hit_ok) health_d = health_q - 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    if (A | B) begin
                        orient_d = o_eff;
                        state_d  = ST_ATTACK;
                        atk_load = 1'b1;
                        sword_d  = tgt_ok ? {SWORD_ID, o_eff, tgt_x, tgt_y} : HIDDEN_WORD;
                    end else if (dir_pressed) begin
                        orient_d = dir_orient;
                        if (mv_zero && tgt_ok) begin
                            x_d     = tgt_x;
                            y_d     = tgt_y;
                            mv_load = 1'b1;
                        end
                    end
                end
            end
            ST_ATTACK: begin
                if (frame_tick && atk_cnt == AW'(1)) begin
                    state_d = ST_IDLE;
                    sword_d = HIDDEN_WORD;
                end
            end
            ST_DEAD: begin
                if (restart) begin
                    state_d  = ST_IDLE;
                    x_d      = COORD_W'(START_X);
                    y_d      = COORD_W'(START_Y);
                    orient_d = ORIENT_RIGHT;
                    sword_d  = HIDDEN_WORD;
                    health_d = HEALTH_W'(MAX_HEALTH);
                    mv_load  = 1'b1;
                    mv_val   = '0;
                    atk_load = 1'b1;
                    atk_val  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Health already at zero overrides whatever the tick decided this cycle.
        if (health_q == '0 && state_q != ST_DEAD) begin
            state_d  = ST_DEAD;
            x_d      = x_q;
            y_d      = y_q;
            orient_d = orient_q;
            sword_d  = HIDDEN_WORD;
            mv_load  = 1'b0;
            atk_load = 1'b0;
        end

        ifr_load = hit_ok | restart;
        ifr_val  = hit_ok ? IW'(IFRAMES) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= COORD_W'(START_X);
            y_q      <= COORD_W'(START_Y);
            orient_q <= ORIENT_RIGHT;
            sword_q  <= HIDDEN_WORD;
            health_q <= HEALTH_W'(MAX_HEALTH);
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            orient_q <= orient_d;
            sword_q  <= sword_d;
            health_q <= health_d;
        end
    end

    assign player        = {PLAYER_ID, orient_q, x_q, y_q};
    assign sword         = sword_q;
    assign player_health = health_q;
    assign invuln        = ~ifr_zero;
    assign game_over     = (state_q == ST_DEAD);
    assign dbg_state     = state_q;

    logic unused_bits;
    assign unused_bits = ^{select, mv_cnt, ifr_cnt, atk_zero};

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: default 16x12 instance plus a 20-wide instance
// for the long-walk edge check.
module tb_player_ctrl;
    import player_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0;
    logic a_btn = 1'b0, b_btn = 1'b0, select = 1'b0, start = 1'b0;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, hit = 1'b0;

    logic [13:0] player, sword;
    logic [1:0]  health;
    logic        invuln, game_over;
    state_t      dbg_state;

    logic [15:0] player2, sword2;
    logic [1:0]  health2;
    logic        invuln2, game_over2;
    state_t      dbg_state2;

    localparam logic [13:0] P_RESET  = {4'h2, 2'b01, 4'd7, 4'd5};
    localparam logic [13:0] S_HIDDEN = {4'hF, 2'b01, 8'd0};

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    player_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .A(a_btn), .B(b_btn), .select(select), .start(start),
        .up(up), .down(down), .left(left), .right(right), .hit(hit),
        .player(player), .sword(sword), .player_health(health),
        .invuln(invuln), .game_over(game_over), .dbg_state(dbg_state)
    );

    player_ctrl #(.GRID_W(20), .COORD_W(5)) dut_wide (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .A(a_btn), .B(b_btn), .select(select), .start(start),
        .up(up), .down(down), .left(left), .right(right), .hit(hit),
        .player(player2), .sword(sword2), .player_health(health2),
        .invuln(invuln2), .game_over(game_over2), .dbg_state(dbg_state2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        {a_btn, b_btn, start, up, down, left, right, hit, frame_tick} = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // driver tasks: everything changes on the falling edge and is sampled there
    task automatic do_tick(input logic h);
        @(negedge clk);
        frame_tick = 1'b1;
        hit = h;
        @(negedge clk);
        frame_tick = 1'b0;
        hit = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0);
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_player", 32'(player), 32'(P_RESET));
        check("rst_sword", 32'(sword), 32'(S_HIDDEN));
        check("rst_health", 32'(health), 32'd3);
        check("rst_invuln", 32'(invuln), 32'd0);
        check("rst_gameover", 32'(game_over), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // hold right for 8 ticks: X moves on tick 1 and tick 5
        for (int k = 1; k <= 8; k++) exp_q.push_back((k < 5) ? 32'd8 : 32'd9);
        right = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            do_tick(1'b0);
            check($sformatf("walk_x_t%0d", k), 32'(player[7:4]), exp_q.pop_front());
        end
        right = 1'b0;
        check("walk_orient", 32'(player[9:8]), 32'd1);

        // walk to the left edge, then turn at the edge without loading the cooldown
        do_reset();
        left = 1'b1;
        idle_ticks(40);
        left = 1'b0;
        check("left_edge_x", 32'(player[7:4]), 32'd0);
        down = 1'b1;
        do_tick(1'b0);
        down = 1'b0;
        check("down_y", 32'(player[3:0]), 32'd6);
        check("down_orient", 32'(player[9:8]), 32'd2);
        idle_ticks(4);
        left = 1'b1;
        do_tick(1'b0);
        left = 1'b0;
        check("edge_turn_orient", 32'(player[9:8]), 32'd3);
        check("edge_turn_x", 32'(player[7:4]), 32'd0);
        right = 1'b1;
        do_tick(1'b0);
        right = 1'b0;
        check("edge_no_cd_x", 32'(player[7:4]), 32'd1);
        check("edge_no_cd_orient", 32'(player[9:8]), 32'd1);

        // 20-wide grid: walk right and stop at X=19
        do_reset();
        right = 1'b1;
        idle_ticks(60);
        right = 1'b0;
        check("wide_x", 32'(player2[9:5]), 32'd19);
        check("wide_y", 32'(player2[4:0]), 32'd5);
        check("wide_orient", 32'(player2[11:10]), 32'd1);

        // attack facing right: sword at (8,5) for exactly 3 ticks
        do_reset();
        a_btn = 1'b1;
        do_tick(1'b0);
        a_btn = 1'b0;
        check("atk_sword_1", 32'(sword), 32'({4'h1, 2'b01, 4'd8, 4'd5}));
        check("atk_state", 32'(dbg_state), 32'(ST_ATTACK));
        a_btn = 1'b1;
        right = 1'b1;
        do_tick(1'b0);
        a_btn = 1'b0;
        right = 1'b0;
        check("atk_sword_2", 32'(sword), 32'({4'h1, 2'b01, 4'd8, 4'd5}));
        check("atk_frozen", 32'(player), 32'(P_RESET));
        do_tick(1'b0);
        check("atk_sword_3", 32'(sword), 32'({4'h1, 2'b01, 4'd8, 4'd5}));
        do_tick(1'b0);
        check("atk_hidden", 32'(sword), 32'(S_HIDDEN));
        check("atk_back_idle", 32'(dbg_state), 32'(ST_IDLE));
        // earliest re-attack, with a direction turning the player first
        a_btn = 1'b1;
        up = 1'b1;
        do_tick(1'b0);
        a_btn = 1'b0;
        up = 1'b0;
        check("reatk_sword", 32'(sword), 32'({4'h1, 2'b00, 4'd7, 4'd4}));
        check("reatk_player", 32'(player), 32'({4'h2, 2'b00, 4'd7, 4'd5}));
        idle_ticks(3);
        check("reatk_done", 32'(dbg_state), 32'(ST_IDLE));

        // facing up at Y=0: sword stays hidden, attack still lasts 3 ticks
        do_reset();
        up = 1'b1;
        idle_ticks(20);
        up = 1'b0;
        check("top_y", 32'(player[3:0]), 32'd0);
        b_btn = 1'b1;
        do_tick(1'b0);
        b_btn = 1'b0;
        check("offgrid_hidden", 32'(sword), 32'(S_HIDDEN));
        check("offgrid_state", 32'(dbg_state), 32'(ST_ATTACK));
        idle_ticks(2);
        check("offgrid_still_atk", 32'(dbg_state), 32'(ST_ATTACK));
        check("offgrid_hidden_3", 32'(sword), 32'(S_HIDDEN));
        do_tick(1'b0);
        check("offgrid_idle", 32'(dbg_state), 32'(ST_IDLE));

        // hits on ticks 0, 2 and 9 with 8 i-frames
        do_reset();
        for (int k = 0; k <= 9; k++) exp_q.push_back((k < 9) ? 32'd2 : 32'd1);
        for (int k = 0; k <= 9; k++) begin
            do_tick((k == 0) || (k == 2) || (k == 9));
            check($sformatf("iframe_health_t%0d", k), 32'(health), exp_q.pop_front());
            check($sformatf("iframe_invuln_t%0d", k), 32'(invuln), (k == 8) ? 32'd0 : 32'd1);
        end

        // three spaced hits (off-tick) lead to game over two cycles after the last one
        do_reset();
        hit_pulse();
        check("hit1_health", 32'(health), 32'd2);
        check("hit1_invuln", 32'(invuln), 32'd1);
        idle_ticks(8);
        check("hit1_iframes_over", 32'(invuln), 32'd0);
        hit_pulse();
        idle_ticks(8);
        hit_pulse();
        check("hit3_health", 32'(health), 32'd0);
        check("hit3_gameover_t1", 32'(game_over), 32'd0);
        @(negedge clk);
        check("hit3_gameover_t2", 32'(game_over), 32'd1);
        check("dead_state", 32'(dbg_state), 32'(ST_DEAD));
        idle_ticks(8);
        right = 1'b1;
        do_tick(1'b1);
        right = 1'b0;
        check("dead_hit_ignored", 32'(health), 32'd0);
        check("dead_no_invuln", 32'(invuln), 32'd0);
        check("dead_frozen", 32'(player), 32'(P_RESET));
        check("dead_sword", 32'(sword), 32'(S_HIDDEN));
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("start_needs_tick", 32'(game_over), 32'd1);
        do_tick(1'b0);
        start = 1'b0;
        check("restart_player", 32'(player), 32'(P_RESET));
        check("restart_health", 32'(health), 32'd3);
        check("restart_gameover", 32'(game_over), 32'd0);
        check("restart_state", 32'(dbg_state), 32'(ST_IDLE));

        // asynchronous reset mid-cooldown and mid-attack
        do_reset();
        right = 1'b1;
        do_tick(1'b0);
        right = 1'b0;
        a_btn = 1'b1;
        do_tick(1'b0);
        a_btn = 1'b0;
        check("pre_areset_sword", 32'(sword), 32'({4'h1, 2'b01, 4'd9, 4'd5}));
        #2 reset = 1'b0;
        #1;
        check("areset_sword", 32'(sword), 32'(S_HIDDEN));
        check("areset_player", 32'(player), 32'(P_RESET));
        check("areset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        right = 1'b1;
        do_tick(1'b0);
        right = 1'b0;
        check("areset_cd_cleared", 32'(player[7:4]), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
